// File: rtl/system_worker_cpu_mult_pkg.sv
// Shared opcode encodings and operand-signedness decode for the worker CPU multiplier.
package system_worker_cpu_mult_pkg;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSS = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXUU = 2'd3;

    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == OP_MULXSS) || (op == OP_MULXSU);
    endfunction

    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == OP_MULXSS);
    endfunction

endpackage

// File: rtl/system_worker_cpu_mult_pp.sv
// One registered HxH unsigned partial product; intended to map onto a single DSP multiplier.
module system_worker_cpu_mult_pp #(
    parameter int H = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    logic [2*H-1:0] p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = {{H{1'b0}}, a} * {{H{1'b0}}, b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/system_worker_cpu_mult_unit.sv
// Pipelined DATA_W x DATA_W multiplier returning the low word or the signed/unsigned high word.
module system_worker_cpu_mult_unit
    import system_worker_cpu_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result
);

    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    // Valid shift register: flush clears every stage even while stalled.
    logic [LATENCY-1:0] vld_q, vld_d;

    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (en) begin
            vld_d[0] = in_valid;
            for (int k = 1; k < LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1];

    // Stage 1: partial products plus the operands needed for signed correction.
    logic [1:0]        op_p1_q, op_p1_d;
    logic [DATA_W-1:0] a_p1_q, a_p1_d, b_p1_q, b_p1_d;
    logic [DATA_W-1:0] ll_p1, lh_p1, hl_p1, hh_p1;

    always_comb begin
        op_p1_d = op_p1_q;
        a_p1_d  = a_p1_q;
        b_p1_d  = b_p1_q;
        if (en) begin
            op_p1_d = in_op;
            a_p1_d  = in_src1;
            b_p1_d  = in_src2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_p1_q <= '0;
            a_p1_q  <= '0;
            b_p1_q  <= '0;
        end else begin
            op_p1_q <= op_p1_d;
            a_p1_q  <= a_p1_d;
            b_p1_q  <= b_p1_d;
        end
    end

    system_worker_cpu_mult_pp #(.H(H)) u_pp_ll (.clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[H-1:0]), .b(in_src2[H-1:0]), .p(ll_p1));
    system_worker_cpu_mult_pp #(.H(H)) u_pp_lh (.clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[H-1:0]), .b(in_src2[DATA_W-1:H]), .p(lh_p1));
    system_worker_cpu_mult_pp #(.H(H)) u_pp_hl (.clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[DATA_W-1:H]), .b(in_src2[H-1:0]), .p(hl_p1));
    system_worker_cpu_mult_pp #(.H(H)) u_pp_hh (.clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[DATA_W-1:H]), .b(in_src2[DATA_W-1:H]), .p(hh_p1));

    // Unsigned full product, then two's-complement fix-up of the high word only.
    logic [PW-1:0]     prod_p1;
    logic [DATA_W-1:0] corr_a_p1, corr_b_p1, hi_p1, lo_p1;

    always_comb begin
        prod_p1   = {hh_p1, ll_p1}
                  + {{H{1'b0}}, lh_p1, {H{1'b0}}}
                  + {{H{1'b0}}, hl_p1, {H{1'b0}}};
        corr_a_p1 = (op_a_signed(op_p1_q) && a_p1_q[DATA_W-1]) ? b_p1_q : '0;
        corr_b_p1 = (op_b_signed(op_p1_q) && b_p1_q[DATA_W-1]) ? a_p1_q : '0;
        hi_p1     = prod_p1[PW-1:DATA_W] - corr_a_p1 - corr_b_p1;
        lo_p1     = prod_p1[DATA_W-1:0];
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign out_result = (op_p1_q == OP_MUL) ? lo_p1 : hi_p1;
        end else begin : g_lat23
            // Stage 2: registered sum and correction.
            logic [1:0]        op_p2_q;
            logic [DATA_W-1:0] lo_p2_q, hi_p2_q, sel_p2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    op_p2_q <= '0;
                    lo_p2_q <= '0;
                    hi_p2_q <= '0;
                end else if (en) begin
                    op_p2_q <= op_p1_q;
                    lo_p2_q <= lo_p1;
                    hi_p2_q <= hi_p1;
                end
            end

            assign sel_p2 = (op_p2_q == OP_MUL) ? lo_p2_q : hi_p2_q;

            if (LATENCY == 2) begin : g_lat2
                assign out_result = sel_p2;
            end else begin : g_lat3
                // Stage 3: registered output word.
                logic [DATA_W-1:0] res_p3_q;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        res_p3_q <= '0;
                    end else if (en) begin
                        res_p3_q <= sel_p2;
                    end
                end

                assign out_result = res_p3_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_system_worker_cpu_mult_unit.sv
// Bench for the pipelined multiplier: three latency variants share one stimulus stream.
module tb_system_worker_cpu_mult_unit;

    logic        clk = 1'b0;
    logic        reset_n, en, flush, in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2;
    logic        v1, v2, v3;
    logic [31:0] r1, r2, r3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    system_worker_cpu_mult_unit #(.DATA_W(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(v1), .out_result(r1));
    system_worker_cpu_mult_unit #(.DATA_W(32), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(v2), .out_result(r2));
    system_worker_cpu_mult_unit #(.DATA_W(32), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(v3), .out_result(r3));

    // Reference: sign/zero-extend to 128 bits, multiply, pick the word.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [127:0] ea, eb, p;
        ea = ((op == 2'd1 || op == 2'd2) && a[31]) ? {{96{1'b1}}, a} : {96'b0, a};
        eb = ((op == 2'd1) && b[31]) ? {{96{1'b1}}, b} : {96'b0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = 2'd0; in_src1 = '0; in_src2 = '0;
        #12;
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_v1 got %b want 0", v1); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL reset_v2 got %b want 0", v2); end
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL reset_v3 got %b want 0", v3); end
        checks++; if (r2 !== 32'h0) begin errors++; $display("FAIL reset_r2 got %h want 0", r2); end
        checks++; if (r3 !== 32'h0) begin errors++; $display("FAIL reset_r3 got %h want 0", r3); end
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mul_latency();
        issue(2'd0, 32'h0001_0003, 32'h0002_0005);
        tick();
        in_valid = 1'b0;
        checks++; if (v1 !== 1'b1 || r1 !== 32'h000B_000F) begin
            errors++; $display("FAIL lat1_result got v=%b %h want v=1 000b000f", v1, r1); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL lat2_early got %b want 0", v2); end
        tick();
        checks++; if (v2 !== 1'b1 || r2 !== 32'h000B_000F) begin
            errors++; $display("FAIL lat2_result got v=%b %h want v=1 000b000f", v2, r2); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL lat1_pulse got %b want 0", v1); end
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL lat3_early got %b want 0", v3); end
        tick();
        checks++; if (v3 !== 1'b1 || r3 !== 32'h000B_000F) begin
            errors++; $display("FAIL lat3_result got v=%b %h want v=1 000b000f", v3, r3); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL lat2_pulse got %b want 0", v2); end
        tick();
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL lat3_pulse got %b want 0", v3); end
    endtask

    logic [1:0]  tab_op  [5] = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd0};
    logic [31:0] tab_a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tab_exp [5] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000};

    task automatic test_high_words();
        for (int i = 0; i < 5; i++) begin
            issue(tab_op[i], tab_a[i], tab_a[i]);
            tick();
            in_valid = 1'b0;
            tick();
            checks++; if (v2 !== 1'b1 || r2 !== tab_exp[i]) begin
                errors++; $display("FAIL high_word_%0d got v=%b %h want v=1 %h", i, v2, r2, tab_exp[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            issue(tab_op[i], tab_a[i], tab_a[i]);
            tick();
            if (i > 0) begin
                checks++; if (v2 !== 1'b1 || r2 !== tab_exp[i-1]) begin
                    errors++; $display("FAIL b2b_%0d got v=%b %h want v=1 %h", i-1, v2, r2, tab_exp[i-1]); end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (v2 !== 1'b1 || r2 !== tab_exp[3]) begin
            errors++; $display("FAIL b2b_3 got v=%b %h want v=1 %h", v2, r2, tab_exp[3]); end
        tick();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", v2); end
    endtask

    task automatic test_stall();
        issue(2'd0, 32'd3, 32'd5);
        tick();
        in_valid = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL stall_v2_%0d got %b want 0", i, v2); end
            checks++; if (v1 !== 1'b1 || r1 !== 32'd15) begin
                errors++; $display("FAIL stall_hold_lat1_%0d got v=%b %h want v=1 0000000f", i, v1, r1); end
        end
        en = 1'b1;
        tick();
        checks++; if (v2 !== 1'b1 || r2 !== 32'd15) begin
            errors++; $display("FAIL stall_result got v=%b %h want v=1 0000000f", v2, r2); end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (v2 !== 1'b1 || r2 !== 32'd15) begin
                errors++; $display("FAIL stall_hold_%0d got v=%b %h want v=1 0000000f", i, v2, r2); end
        end
        en = 1'b1;
        tick();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", v2); end
        tick();
    endtask

    task automatic test_flush();
        issue(2'd0, 32'h0001_0003, 32'h0002_0005);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (v1 !== 1'b0 || v2 !== 1'b0 || v3 !== 1'b0) begin
                errors++; $display("FAIL flush_kill_%0d got %b%b%b want 000", i, v1, v2, v3); end
            tick();
        end
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (v1 !== 1'b0 || v2 !== 1'b0 || v3 !== 1'b0) begin
                errors++; $display("FAIL flush_with_issue_%0d got %b%b%b want 000", i, v1, v2, v3); end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        issue(2'd0, 32'h0001_0003, 32'h0002_0005);
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (v1 !== 1'b0 || r1 !== 32'h0) begin
            errors++; $display("FAIL midreset_lat1 got v=%b %h want v=0 0", v1, r1); end
        checks++; if (r2 !== 32'h0 || r3 !== 32'h0) begin
            errors++; $display("FAIL midreset_data got %h %h want 0 0", r2, r3); end
        #1 reset_n = 1'b1;
        tick();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL midreset_lat2 got %b want 0", v2); end
        tick();
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL midreset_lat3 got %b want 0", v3); end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Model: an op accepted on the k-th enabled edge is visible at LATENCY L while
    // the enabled-edge count equals k+L-1, unless a flush has happened since.
    task automatic test_random();
        logic [31:0] accepted [int];
        int          e_cnt;
        int          idx;
        logic        exp_v;
        logic        got_v;
        logic [31:0] got_r;

        in_valid = 1'b0; en = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        e_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en       = ($urandom_range(0, 9) < 8);
            flush    = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_op    = 2'($urandom_range(0, 3));
            in_src1  = pick_operand();
            in_src2  = pick_operand();
            if (flush) begin
                accepted.delete();
            end else if (en) begin
                e_cnt++;
                if (in_valid) accepted[e_cnt] = ref_mul(in_op, in_src1, in_src2);
            end
            tick();
            for (int L = 1; L <= 3; L++) begin
                idx   = e_cnt - L + 1;
                exp_v = accepted.exists(idx);
                got_v = (L == 1) ? v1 : (L == 2) ? v2 : v3;
                got_r = (L == 1) ? r1 : (L == 2) ? r2 : r3;
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL rand_valid_lat%0d cyc %0d got %b want %b", L, cyc, got_v, exp_v);
                end else if (exp_v) begin
                    checks++;
                    if (got_r !== accepted[idx]) begin
                        errors++;
                        $display("FAIL rand_result_lat%0d cyc %0d got %h want %h", L, cyc, got_r, accepted[idx]);
                    end
                end
            end
        end
        en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_high_words();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
